// File: rtl/alu_op_driver.sv
// alu_op_driver
//   Front-end that owns the ALU input bus. It accepts one operation per
//   req_valid/req_ready handshake. The operation goes to the ALU either as
//   one combined-operand cycle or as two split-operand cycles (opa, then opb).
//   The block then waits LATENCY edges, captures res and the flags, and
//   returns them on the rsp_valid/rsp_ready channel. Only one operation is
//   ever outstanding.
//
//   Optional feature macro: ALU_DRV_STATS_EN
//     adds stat_ops / stat_errs (saturating handshake and error counters).
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   req_*               host request channel (valid/ready plus operation fields)
//   ce, opa, opb, mode, inp_valid, cmd, cin
//                       registered ALU input bus
//   res, err, cout, oflow, g, l, e
//                       ALU outputs
//   rsp_valid/ready     response handshake
//   rsp_res, rsp_flags  captured result and flags {err, cout, oflow, g, l, e}
//   stat_ops, stat_errs (ALU_DRV_STATS_EN only) response and error counts
module alu_op_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int RES_WIDTH  = 16,
  parameter int LATENCY    = 1,
  parameter int SPLIT_GAP  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_opa,
  input  logic [DATA_WIDTH-1:0] req_opb,
  input  logic                  req_mode,
  input  logic [CMD_WIDTH-1:0]  req_cmd,
  input  logic                  req_cin,
  input  logic [1:0]            req_inp_valid,
  input  logic                  req_split,
  output logic                  ce,
  output logic [DATA_WIDTH-1:0] opa,
  output logic [DATA_WIDTH-1:0] opb,
  output logic                  mode,
  output logic [1:0]            inp_valid,
  output logic [CMD_WIDTH-1:0]  cmd,
  output logic                  cin,
  input  logic [RES_WIDTH-1:0]  res,
  input  logic                  err,
  input  logic                  cout,
  input  logic                  oflow,
  input  logic                  g,
  input  logic                  l,
  input  logic                  e,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RES_WIDTH-1:0]  rsp_res,
  output logic [5:0]            rsp_flags
`ifdef ALU_DRV_STATS_EN
  ,
  output logic [15:0]           stat_ops,
  output logic [15:0]           stat_errs
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE_AB = 3'd1,
    ST_ISSUE_A  = 3'd2,
    ST_GAP      = 3'd3,
    ST_ISSUE_B  = 3'd4,
    ST_WAIT     = 3'd5,
    ST_RESP     = 3'd6
  } state_e;

  // Both counters count down and exit on 1, so WAIT lasts LATENCY-1 cycles
  // and GAP lasts SPLIT_GAP cycles.
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);
  localparam logic [3:0] GAP_LOAD = 4'(SPLIT_GAP);
  localparam bit         LAT_ONE  = (LATENCY == 1);
  localparam bit         GAP_NONE = (SPLIT_GAP == 0);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  capture_s;
  logic [DATA_WIDTH-1:0] opb_lat_q;

  logic                  ce_q, ce_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic                  mode_q, mode_d, cin_q, cin_d;
  logic [1:0]            inp_valid_q, inp_valid_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [RES_WIDTH-1:0]  rsp_res_q;
  logic [5:0]            rsp_flags_q;

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. LATENCY=1 skips WAIT and captures on the edge that
  // leaves the issue state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (req_split && (req_inp_valid == 2'b11)) begin
            state_d = ST_ISSUE_A;
          end else begin
            state_d = ST_ISSUE_AB;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE_AB, ST_ISSUE_B: begin
        if (LAT_ONE) begin
          capture_s = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_ISSUE_A: begin
        if (GAP_NONE) begin
          state_d = ST_ISSUE_B;
        end else begin
          cnt_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_ISSUE_B;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          capture_s = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values, decoded from the next state so that every output
  // comes straight from a flop. The issue states are entered only on the
  // accept edge, so they take the operation fields directly from req_*.
  // ISSUE_B uses the stored opb and keeps opa/mode/cmd/cin from ISSUE_A.
  always_comb begin
    ce_d        = 1'b0;
    opa_d       = opa_q;
    opb_d       = opb_q;
    mode_d      = mode_q;
    inp_valid_d = inp_valid_q;
    cmd_d       = cmd_q;
    cin_d       = cin_q;
    case (state_d)
      ST_ISSUE_AB: begin
        ce_d        = 1'b1;
        opa_d       = req_opa;
        opb_d       = req_opb;
        mode_d      = req_mode;
        inp_valid_d = req_inp_valid;
        cmd_d       = req_cmd;
        cin_d       = req_cin;
      end
      ST_ISSUE_A: begin
        ce_d        = 1'b1;
        opa_d       = req_opa;
        opb_d       = {DATA_WIDTH{1'b0}};
        mode_d      = req_mode;
        inp_valid_d = 2'b01;
        cmd_d       = req_cmd;
        cin_d       = req_cin;
      end
      ST_ISSUE_B: begin
        ce_d        = 1'b1;
        opb_d       = opb_lat_q;
        inp_valid_d = 2'b10;
      end
      ST_WAIT: ce_d = 1'b1;
      default: ce_d = 1'b0;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // Registered ALU bus, handshake outputs, request latch and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q        <= 1'b0;
      opa_q       <= {DATA_WIDTH{1'b0}};
      opb_q       <= {DATA_WIDTH{1'b0}};
      mode_q      <= 1'b0;
      inp_valid_q <= 2'b00;
      cmd_q       <= {CMD_WIDTH{1'b0}};
      cin_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      opb_lat_q   <= {DATA_WIDTH{1'b0}};
      rsp_res_q   <= {RES_WIDTH{1'b0}};
      rsp_flags_q <= 6'd0;
    end else begin
      ce_q        <= ce_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      mode_q      <= mode_d;
      inp_valid_q <= inp_valid_d;
      cmd_q       <= cmd_d;
      cin_q       <= cin_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      if (req_valid && req_ready_q) begin
        opb_lat_q <= req_opb;
      end
      if (capture_s) begin
        rsp_res_q   <= res;
        rsp_flags_q <= {err, cout, oflow, g, l, e};
      end
    end
  end

  assign ce        = ce_q;
  assign opa       = opa_q;
  assign opb       = opb_q;
  assign mode      = mode_q;
  assign inp_valid = inp_valid_q;
  assign cmd       = cmd_q;
  assign cin       = cin_q;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_flags = rsp_flags_q;

`ifdef ALU_DRV_STATS_EN
  logic [15:0] stat_ops_q, stat_errs_q;

  // Saturating counters of completed responses and of responses carrying err
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ops_q  <= 16'd0;
      stat_errs_q <= 16'd0;
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      if (stat_ops_q != 16'hFFFF) begin
        stat_ops_q <= stat_ops_q + 16'd1;
      end
      if (rsp_flags_q[5] && (stat_errs_q != 16'hFFFF)) begin
        stat_errs_q <= stat_errs_q + 16'd1;
      end
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// Testbench for alu_op_driver. Instance 0 uses LATENCY=1, SPLIT_GAP=2.
// Instance 1 uses LATENCY=3, SPLIT_GAP=0. A small combinational ALU model
// drives res and the flags. Expected results go into a queue when a request
// is driven and are popped when the response appears.
module tb_alu_op_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid[2], req_ready[2], req_mode[2], req_cin[2], req_split[2];
  logic [7:0]  req_opa[2], req_opb[2];
  logic [3:0]  req_cmd[2];
  logic [1:0]  req_inp_valid[2];
  logic        ce[2], mode[2], cin[2], rsp_valid[2], rsp_ready[2];
  logic [7:0]  opa[2], opb[2];
  logic [1:0]  inp_valid[2];
  logic [3:0]  cmd[2];
  logic [15:0] rsp_res[2];
  logic [5:0]  rsp_flags[2];
  logic [21:0] alu_out[2];
`ifdef ALU_DRV_STATS_EN
  logic [15:0] stat_ops[2], stat_errs[2];
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_ops = 0;
  int          exp_errs = 0;
  logic [21:0] sb_q[$];
  logic [21:0] last_got;

  always #5 clk = ~clk;

  // ALU model: {err, cout, oflow, g, l, e, res[15:0]}. Outputs are zero while ce=0.
  function automatic logic [21:0] alu_f(input logic c_en, input logic [7:0] a, input logic [7:0] b,
                                        input logic m, input logic [3:0] c, input logic ci,
                                        input logic [1:0] iv);
    logic [15:0] r;
    logic        er;
    logic        co;
    r  = 16'h0000;
    er = 1'b0;
    if (!c_en) return 22'h0;
    if (iv == 2'b00) begin
      er = 1'b1;
    end else if (m) begin
      case (c)
        4'd0:    r = {8'h00, a} + {8'h00, b};
        4'd1:    r = {8'h00, a} - {8'h00, b};
        4'd2:    r = {8'h00, a} + {8'h00, b} + {15'h0000, ci};
        default: r = 16'h0000;
      endcase
    end else begin
      case (c)
        4'd0:    r = {8'h00, a & b};
        4'd1:    r = {8'h00, a | b};
        4'd2:    r = {8'h00, a ^ b};
        default: r = 16'h0000;
      endcase
    end
    co = m & r[8] & ~er;
    return {er, co, 1'b0, (a > b), (a < b), (a == b), r};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign alu_out[gi] = alu_f(ce[gi], opa[gi], opb[gi], mode[gi], cmd[gi], cin[gi], inp_valid[gi]);

    alu_op_driver #(
      .DATA_WIDTH(8), .CMD_WIDTH(4), .RES_WIDTH(16),
      .LATENCY((gi == 0) ? 1 : 3), .SPLIT_GAP((gi == 0) ? 2 : 0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[gi]), .req_ready(req_ready[gi]),
      .req_opa(req_opa[gi]), .req_opb(req_opb[gi]), .req_mode(req_mode[gi]),
      .req_cmd(req_cmd[gi]), .req_cin(req_cin[gi]), .req_inp_valid(req_inp_valid[gi]),
      .req_split(req_split[gi]),
      .ce(ce[gi]), .opa(opa[gi]), .opb(opb[gi]), .mode(mode[gi]),
      .inp_valid(inp_valid[gi]), .cmd(cmd[gi]), .cin(cin[gi]),
      .res(alu_out[gi][15:0]), .err(alu_out[gi][21]), .cout(alu_out[gi][20]),
      .oflow(alu_out[gi][19]), .g(alu_out[gi][18]), .l(alu_out[gi][17]), .e(alu_out[gi][16]),
      .rsp_valid(rsp_valid[gi]), .rsp_ready(rsp_ready[gi]),
      .rsp_res(rsp_res[gi]), .rsp_flags(rsp_flags[gi])
`ifdef ALU_DRV_STATS_EN
      , .stat_ops(stat_ops[gi]), .stat_errs(stat_errs[gi])
`endif
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one operation on instance k, trace the bus until the response
  // appears, hold rsp_ready low for `hold` cycles, then complete the handshake.
  task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic m,
                        input logic [3:0] c, input logic ci, input logic [1:0] iv,
                        input logic sp, input int hold);
    int          n;
    int          cyc;
    int          ce_cnt;
    int          lat;
    int          gp;
    logic        eff_split;
    logic [7:0]  first_opb;
    logic [1:0]  first_iv;
    logic [1:0]  last_iv;
    logic [21:0] held;
    logic [21:0] exp_v;
    lat       = (k == 0) ? 1 : 3;
    gp        = (k == 0) ? 2 : 0;
    eff_split = sp && (iv == 2'b11);
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready_before", 32'(req_ready[k]), 32'd1);
    req_opa[k] = a; req_opb[k] = b; req_mode[k] = m; req_cmd[k] = c;
    req_cin[k] = ci; req_inp_valid[k] = iv; req_split[k] = sp; req_valid[k] = 1'b1;
    sb_q.push_back(alu_f(1'b1, a, b, m, c, ci, iv));
    @(negedge clk);
    req_valid[k] = 1'b0;
    cyc = 0; ce_cnt = 0; first_opb = 8'h00; first_iv = 2'b00; last_iv = 2'b00;
    while (!rsp_valid[k] && cyc < 60) begin
      if (ce[k]) begin
        if (ce_cnt == 0) begin
          first_opb = opb[k];
          first_iv  = inp_valid[k];
        end
        last_iv = inp_valid[k];
        ce_cnt++;
      end
      cyc++;
      @(negedge clk);
    end
    check_eq("cycles_to_rsp", 32'(cyc), eff_split ? 32'(2 + gp + lat - 1) : 32'(lat));
    check_eq("ce_cycles", 32'(ce_cnt), eff_split ? 32'(1 + lat) : 32'(lat));
    check_eq("first_inp_valid", 32'(first_iv), eff_split ? 32'd1 : 32'(iv));
    check_eq("last_inp_valid", 32'(last_iv), eff_split ? 32'd2 : 32'(iv));
    check_eq("first_opb", 32'(first_opb), eff_split ? 32'd0 : 32'(b));
    held = {rsp_flags[k], rsp_res[k]};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_rsp", 32'({rsp_flags[k], rsp_res[k]}), 32'(held));
      check_eq("hold_valid_rdy_ce", 32'({rsp_valid[k], req_ready[k], ce[k]}), 32'b100);
    end
    check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      last_got = {rsp_flags[k], rsp_res[k]};
      check_eq("rsp_data", 32'(last_got), 32'(exp_v));
      if (k == 0) begin
        exp_ops++;
        if (exp_v[21]) exp_errs++;
      end
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    check_eq("post_hs_valid", 32'(rsp_valid[k]), 32'd0);
    check_eq("post_hs_ready", 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_rsp;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_opa[k] = 8'h00; req_opb[k] = 8'h00; req_mode[k] = 1'b0;
      req_cmd[k] = 4'h0; req_cin[k] = 1'b0; req_inp_valid[k] = 2'b00; req_split[k] = 1'b0;
      rsp_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_bus", 32'({ce[0], opa[0], opb[0], inp_valid[0], rsp_valid[0]}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", 32'({req_ready[0], req_ready[1]}), 32'b11);
    check_eq("idle_ce_valid", 32'({ce[0], rsp_valid[0], ce[1], rsp_valid[1]}), 32'd0);

    // LATENCY=1, SPLIT_GAP=2 instance
    run_op(0, 8'h05, 8'h03, 1'b1, 4'd0, 1'b0, 2'b11, 1'b0, 0);
    check_eq("add_res", 32'(last_got[15:0]), 32'h0008);
    check_eq("add_err", 32'(last_got[21]), 32'd0);
    run_op(0, 8'h0A, 8'h04, 1'b1, 4'd1, 1'b0, 2'b11, 1'b1, 5);
    check_eq("sub_res", 32'(last_got[15:0]), 32'h0006);
    run_op(0, 8'h33, 8'h44, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0, 0);
    check_eq("iv00_err", 32'(last_got[21]), 32'd1);
    run_op(0, 8'hF0, 8'h0F, 1'b0, 4'd1, 1'b0, 2'b01, 1'b1, 1);
    run_op(0, 8'hFF, 8'h02, 1'b1, 4'd2, 1'b1, 2'b11, 1'b0, 0);
    check_eq("addc_res_cout", 32'({last_got[20], last_got[15:0]}), 32'h10102);
`ifdef ALU_DRV_STATS_EN
    check_eq("stat_ops", 32'(stat_ops[0]), 32'(exp_ops));
    check_eq("stat_errs", 32'(stat_errs[0]), 32'(exp_errs));
`endif

    // LATENCY=3 instance: reset in the middle of WAIT
    @(negedge clk);
    req_opa[1] = 8'h11; req_opb[1] = 8'h22; req_mode[1] = 1'b1; req_cmd[1] = 4'd0;
    req_inp_valid[1] = 2'b11; req_split[1] = 1'b0; req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check_eq("wait_ce_before_rst", 32'(ce[1]), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_bus", 32'({ce[1], opa[1], opb[1], inp_valid[1], cmd[1]}), 32'd0);
    check_eq("async_rst_valid", 32'(rsp_valid[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_rsp = saw_rsp | rsp_valid[1];
    end
    check_eq("no_rsp_after_rst", 32'(saw_rsp), 32'd0);
`ifdef ALU_DRV_STATS_EN
    check_eq("stat_ops_rst", 32'(stat_ops[0]), 32'd0);
    check_eq("stat_errs_rst", 32'(stat_errs[0]), 32'd0);
`endif
    run_op(1, 8'h21, 8'h12, 1'b1, 4'd0, 1'b0, 2'b11, 1'b0, 2);
    check_eq("l3_add_res", 32'(last_got[15:0]), 32'h0033);
    run_op(1, 8'h0C, 8'h0A, 1'b0, 4'd2, 1'b0, 2'b11, 1'b1, 0);
    check_eq("l3_xor_res", 32'(last_got[15:0]), 32'h0006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_driver.md
Name: alu_op_driver

Overview:
- Synthesizable front-end that owns the ALU input bus: ce, opa, opb, mode, inp_valid, cmd, cin.
- Accepts one operation per valid/ready handshake from a host. Issues it to the ALU either as a combined-operand cycle or as two split-operand cycles. Waits a fixed latency, captures res and flags, and returns them on a valid/ready response channel.
- Sits between the host/sequencer-side logic and the ALU core; the ALU's existing checker observes the bus this block drives.

Parameters:
- DATA_WIDTH, 8, operand width.
- CMD_WIDTH, 4, command width.
- RES_WIDTH, 16, ALU result width.
- LATENCY, 1, rising edges from the issue edge to the edge that samples ALU outputs; legal range 1..15.
- SPLIT_GAP, 2, idle cycles (ce=0) between the split opa and opb issue cycles; legal range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  host operation valid
- req_ready  out  1  driver can accept an operation
- req_opa  in  DATA_WIDTH  operand A
- req_opb  in  DATA_WIDTH  operand B
- req_mode  in  1  1 = arithmetic, 0 = logical
- req_cmd  in  CMD_WIDTH  ALU command
- req_cin  in  1  carry in
- req_inp_valid  in  2  operand-valid pattern for the ALU
- req_split  in  1  issue opa and opb in separate cycles
- ce  out  1  ALU clock enable
- opa  out  DATA_WIDTH  to ALU
- opb  out  DATA_WIDTH  to ALU
- mode  out  1  to ALU
- inp_valid  out  2  to ALU
- cmd  out  CMD_WIDTH  to ALU
- cin  out  1  to ALU
- res  in  RES_WIDTH  ALU result
- err, cout, oflow, g, l, e  in  1 each  ALU flags
- rsp_valid  out  1  captured result valid
- rsp_ready  in  1  host accepts result
- rsp_res  out  RES_WIDTH  captured res
- rsp_flags  out  6  {err, cout, oflow, g, l, e}

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0, except req_ready=1 in IDLE after reset. Any in-flight operation is discarded; no response is produced for it.
- All ALU-bus outputs are registered. When not in an issue or WAIT state: ce=0, and opa/opb/mode/cmd/cin/inp_valid hold their last values (never X).
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch all req_* fields.
  - Go to ISSUE_A if req_split=1 and req_inp_valid=2'b11; otherwise go to ISSUE_AB.
- ISSUE_AB (1 cycle): ce=1, opa, opb, mode, cmd, cin driven, inp_valid=latched pattern. This is the issue edge. Next state is WAIT.
- ISSUE_A (1 cycle): ce=1, inp_valid=2'b01, opa driven, opb=0.
  - Next state is GAP if SPLIT_GAP>0, else ISSUE_B.
- GAP: ce=0 for SPLIT_GAP cycles, counted by a down-counter. Next state is ISSUE_B.
- ISSUE_B (1 cycle): ce=1, inp_valid=2'b10, opb driven, opa holds. This is the issue edge. Next state is WAIT.
- WAIT:
  - ce stays 1 and the issue-cycle bus values are held unchanged.
  - Counter loads LATENCY-1 on entry. Sampling occurs on the LATENCY-th edge after the issue edge: capture res into rsp_res and flags into rsp_flags.
  - Then ce=0 and the state goes to RESP.
  - For LATENCY=1, WAIT lasts zero cycles: capture happens on the edge leaving the issue state.
- RESP:
  - rsp_valid=1; rsp_res and rsp_flags are stable until the handshake.
  - On rsp_ready: rsp_valid=0 next cycle and the state goes to IDLE.
  - req_ready=0 throughout RESP, so accepting the next request costs one IDLE cycle.
- inp_valid=2'b00 requests are issued as-is (ISSUE_AB). The ALU's err flag is captured and returned; the driver does not filter it.
- req_split=1 with req_inp_valid≠11 is treated as non-split.
- Only one operation is ever outstanding; no buffering beyond one request and one response.
- ALU inputs are never X after the first post-reset edge.

Optional Feature:
- ALU_DRV_STATS_EN: adds outputs stat_ops[15:0] and stat_errs[15:0].
  - stat_ops increments on every RESP handshake.
  - stat_errs increments when the handshake carries err=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Without the macro: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- LATENCY=1; req opa=8'h05, opb=8'h03, mode=1, cmd=0 (ADD), inp_valid=11, split=0 → exactly one cycle with ce=1, inp_valid=11; rsp_res=16'h0008, rsp_flags err=0.
- split=1, SPLIT_GAP=2, opa=8'h0A, opb=8'h04, cmd=1 (SUB) → ce=1/inp_valid=01, then 2 cycles ce=0, then ce=1/inp_valid=10; rsp_res=16'h0006.
- rsp_ready held 0 for 5 cycles after rsp_valid → rsp_res/rsp_flags stable, req_ready=0, ce=0; after rsp_ready=1, req_ready=1 the following cycle.
- inp_valid=2'b00 request → issued with inp_valid=00; rsp_flags[5] (err)=1 when the ALU flags it; driver returns to IDLE normally.
- rst asserted low mid-WAIT (LATENCY=3) → outputs 0 immediately (asynchronous), no rsp_valid after release, next request processed normally.
- ALU_DRV_STATS_EN defined: 3 ops, one with err → stat_ops=3, stat_errs=1; reset → both 0.
